// File: rtl/translator_pkg.sv
// Flit field layout shared by the packetizer and depacketizer.
// Positions are derived from the flit, vc and address widths.
package translator_pkg;

  localparam int FLIT_W = 36;
  localparam int DATA_W = 12;
  localparam int VC_W   = 1;
  localparam int ADDR_W = 4;

  localparam int CTRL_W = 3;

  function automatic int valid_pos(input int w);
    return w - 1;
  endfunction

  function automatic int head_pos(input int w);
    return w - 2;
  endfunction

  function automatic int tail_pos(input int w);
    return w - 3;
  endfunction

  function automatic int vc_lsb(input int w, input int vw);
    return w - CTRL_W - vw;
  endfunction

  function automatic int dst_lsb(
    input int w,
    input int vw,
    input int aw
  );
    return w - CTRL_W - vw - aw;
  endfunction

  // Payload sits below dst, so its width equals dst's lsb position.
  function automatic int payload_w(
    input int w,
    input int vw,
    input int aw
  );
    return dst_lsb(w, vw, aw);
  endfunction

endpackage

// File: rtl/pkt_fifo2.sv
// Two-entry FIFO with registered occupancy.
// Storage is not reset; only pointers and count are.
module pkt_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (occ != 2'd2);
  assign do_pop  = pop && (occ != 2'd0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/packetizer_1_sub.sv
// Wraps user words into single head+tail NoC flits.
// Two-entry buffer decouples the user side from NoC backpressure.
module packetizer_1_sub
  import translator_pkg::*;
#(
  parameter int WIDTH_PKT        = 36,
  parameter int WIDTH_DATA       = 12,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH_DATA-1:0]       data_in,
  input  logic                        valid_in,
  input  logic [ADDRESS_WIDTH-1:0]    dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
  output logic                        ready_out,
  output logic [WIDTH_PKT-1:0]        data_out,
  input  logic                        ready_in,
  output logic [15:0]                 pkt_count
);

  localparam int VW = VC_ADDRESS_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = WIDTH_DATA;
  localparam int EW = DW + AW + VW;

  localparam int V_POS = valid_pos(WIDTH_PKT);
  localparam int H_POS = head_pos(WIDTH_PKT);
  localparam int T_POS = tail_pos(WIDTH_PKT);
  localparam int V_LSB = vc_lsb(WIDTH_PKT, VW);
  localparam int D_LSB = dst_lsb(WIDTH_PKT, VW, AW);
  localparam int PW    = payload_w(WIDTH_PKT, VW, AW);

  logic          push;
  logic          pop;
  logic [EW-1:0] din;
  logic [EW-1:0] dout;
  logic [1:0]    occ;

  logic [DW-1:0] h_data;
  logic [AW-1:0] h_dst;
  logic [VW-1:0] h_vc;

  // ready depends only on registered occupancy, never on ready_in.
  assign ready_out = (occ != 2'd2);
  assign push      = valid_in && ready_out;
  assign pop       = (occ != 2'd0) && ready_in;
  assign din       = {data_in, dst_in, vc_in};

  assign {h_data, h_dst, h_vc} = dout;

  pkt_fifo2 #(
    .W (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .occ   (occ)
  );

  always_comb begin
    data_out = '0;
    if (occ != 2'd0) begin
      data_out[V_POS]            = 1'b1;
      data_out[H_POS]            = 1'b1;
      data_out[T_POS]            = 1'b1;
      data_out[V_LSB +: VW]      = h_vc;
      data_out[D_LSB +: AW]      = h_dst;
      data_out[PW-1 -: DW]       = h_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= 16'd0;
    end else if (pop && (pkt_count != 16'hFFFF)) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_packetizer_1_sub.sv
// Scoreboard bench for packetizer_1_sub.
// Stimulus pushes expected words; a monitor compares each cycle.
module tb_packetizer_1_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] data_in;
  logic        valid_in;
  logic [3:0]  dst_in;
  logic [0:0]  vc_in;
  logic        ready_out;
  logic [35:0] data_out;
  logic        ready_in;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  packetizer_1_sub dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .dst_in    (dst_in),
    .vc_in     (vc_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .ready_in  (ready_in),
    .pkt_count (pkt_count)
  );

  typedef struct {
    logic [11:0] d;
    logic [3:0]  dst;
    logic        vc;
  } word_t;

  word_t q[$];
  int    sent = 0;
  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b0;

  function automatic logic [35:0] flit(input word_t w);
    return {3'b111, w.vc, w.dst, w.d, 16'h0000};
  endfunction

  function automatic logic [15:0] exp_cnt();
    return (sent > 65535) ? 16'hFFFF : 16'(sent);
  endfunction

  function automatic word_t rnd_word();
    word_t w;
    w.d   = 12'($urandom);
    w.dst = 4'($urandom);
    w.vc  = 1'($urandom);
    return w;
  endfunction

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s actual=%h required=%h t=%0t",
                 name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; expected word is queued at the accepting edge.
  task automatic cyc(
    input  logic  v,
    input  logic  r,
    input  word_t w,
    output bit    acc
  );
    @(negedge clk);
    valid_in = v;
    ready_in = r;
    data_in  = w.d;
    dst_in   = w.dst;
    vc_in    = w.vc;
    acc      = v && ready_out;
    @(posedge clk);
    if (acc) q.push_back(w);
    #1 valid_in = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [35:0] e;
    #2;
    if (mon_en) begin
      e = (q.size() > 0) ? flit(q[0]) : 36'h0;
      check("data_out", 64'(data_out), 64'(e));
      check("ready_out", 64'(ready_out), 64'(q.size() < 2));
      check("pkt_count", 64'(pkt_count), 64'(exp_cnt()));
      if (q.size() > 0 && ready_in) begin
        void'(q.pop_front());
        sent++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w, w1, w2, w3;
    bit    acc;
    int    base;
    int    n;

    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    data_in  = '0;
    dst_in   = '0;
    vc_in    = '0;
    w        = rnd_word();
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", 64'(data_out), 64'h0);
    check("rst_pkt_count", 64'(pkt_count), 64'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    #1 check("rst_ready_out", 64'(ready_out), 64'h1);

    // single word
    w.d = 12'hABC; w.dst = 4'h5; w.vc = 1'b1;
    cyc(1'b1, 1'b1, w, acc);
    check("single_acc", 64'(acc), 64'h1);
    @(negedge clk); #1;
    check("single_flit", 64'(data_out), 64'hF5ABC0000);
    @(negedge clk); #1;
    check("single_count", 64'(pkt_count), 64'h1);

    // backpressure with three words
    w1 = rnd_word(); w2 = rnd_word(); w3 = rnd_word();
    cyc(1'b1, 1'b0, w1, acc);
    check("bp_acc1", 64'(acc), 64'h1);
    cyc(1'b1, 1'b0, w2, acc);
    check("bp_acc2", 64'(acc), 64'h1);
    check("bp_full_rdy", 64'(ready_out), 64'h0);
    cyc(1'b1, 1'b0, w3, acc);
    check("bp_no_push", 64'(acc), 64'h0);
    check("bp_hold", 64'(data_out), 64'(flit(w1)));
    n = 0;
    do begin
      cyc(1'b1, 1'b1, w3, acc);
      n++;
    end while (!acc && n < 5);
    check("bp_acc3", 64'(acc), 64'h1);
    repeat (4) cyc(1'b0, 1'b1, w, acc);
    check("bp_drain", 64'(q.size()), 64'h0);

    // back-to-back streaming
    base = sent;
    n    = 0;
    repeat (100) begin
      cyc(1'b1, 1'b1, rnd_word(), acc);
      if (acc) n++;
    end
    check("stream_accepts", 64'(n), 64'd100);
    cyc(1'b0, 1'b1, w, acc);
    check("stream_flits", 64'(sent - base), 64'd100);

    // random traffic with random backpressure
    repeat (2000)
      cyc(1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 2) != 0), rnd_word(), acc);
    repeat (4) cyc(1'b0, 1'b1, w, acc);
    check("rand_drain", 64'(q.size()), 64'h0);

    // reset with a full buffer
    cyc(1'b1, 1'b0, rnd_word(), acc);
    cyc(1'b1, 1'b0, rnd_word(), acc);
    check("mid_full", 64'(q.size()), 64'd2);
    @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_data", 64'(data_out), 64'h0);
    check("mid_rst_count", 64'(pkt_count), 64'h0);
    q.delete();
    sent = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) cyc(1'b0, 1'b1, w, acc);
    check("mid_no_stale", 64'(data_out), 64'h0);

    // saturation
    repeat (65537) cyc(1'b1, 1'b1, rnd_word(), acc);
    repeat (2) cyc(1'b0, 1'b1, w, acc);
    check("sat_sent", 64'(sent >= 65537), 64'h1);
    check("sat_count", 64'(pkt_count), 64'hFFFF);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
